// File: rtl/pipe_fwd_datapath.sv
// ID/EXE, EXE/MEM and MEM/WB pipeline registers with operand and store-data forwarding.
// Each stage register loads, holds or flushes under the controller's en/rst pair, and its hazard tags are fed back to the controller.
module pipe_fwd_datapath #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exe_en,
    input  logic              exe_rst,
    input  logic              mem_en,
    input  logic              mem_rst,
    input  logic              wb_en,
    input  logic              wb_rst,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic              fwd_mem,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [REG_AW-1:0] id_regw_addr,
    input  logic [REG_AW-1:0] id_addr_rt,
    input  logic              id_wb_wen,
    input  logic              id_is_load,
    input  logic              id_is_store,
    input  logic [DATA_W-1:0] exe_alu_out,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] exe_opa,
    output logic [DATA_W-1:0] exe_opb,
    output logic              exe_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [REG_AW-1:0] regw_addr_exe,
    output logic              wb_wen_exe,
    output logic              is_load_exe,
    output logic              is_store_exe,
    output logic [REG_AW-1:0] regw_addr_mem,
    output logic              wb_wen_mem,
    output logic              is_load_mem,
    output logic              is_store_mem,
    output logic [REG_AW-1:0] addr_rt_mem,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [REG_AW-1:0] regw_addr_wb,
    output logic              wb_wen_wb,
    output logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] exe_opa_q, exe_opb_q;
    logic              exe_valid_q, exe_wen_q, exe_load_q, exe_store_q;
    logic [REG_AW-1:0] exe_regw_q, exe_rt_q;

    logic [DATA_W-1:0] mem_alu_q, mem_sdata_q;
    logic              mem_valid_q, mem_wen_q, mem_load_q, mem_store_q;
    logic [REG_AW-1:0] mem_regw_q, mem_rt_q;

    logic [DATA_W-1:0] wb_data_q;
    logic              wb_valid_q, wb_wen_q;
    logic [REG_AW-1:0] wb_regw_q;

    logic [DATA_W-1:0] opa_d, opb_d, wb_data_d;

    // Select 2 forwards from the EXE/MEM ALU-result register, not the live ALU.
    always_comb begin
        opa_d = id_rs_data;
        unique case (fwd_a)
            2'd0: opa_d = id_rs_data;
            2'd1: opa_d = exe_alu_out;
            2'd2: opa_d = mem_alu_q;
            2'd3: opa_d = mem_rdata;
            default: opa_d = id_rs_data;
        endcase
        opb_d = id_rt_data;
        unique case (fwd_b)
            2'd0: opb_d = id_rt_data;
            2'd1: opb_d = exe_alu_out;
            2'd2: opb_d = mem_alu_q;
            2'd3: opb_d = mem_rdata;
            default: opb_d = id_rt_data;
        endcase
        wb_data_d = mem_load_q ? mem_rdata : mem_alu_q;
    end

    // The forwarded B operand doubles as the store data for this instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || exe_rst) begin
            exe_opa_q   <= '0;
            exe_opb_q   <= '0;
            exe_valid_q <= 1'b0;
            exe_wen_q   <= 1'b0;
            exe_load_q  <= 1'b0;
            exe_store_q <= 1'b0;
            exe_regw_q  <= '0;
            exe_rt_q    <= '0;
        end else if (exe_en) begin
            exe_opa_q   <= opa_d;
            exe_opb_q   <= opb_d;
            exe_valid_q <= 1'b1;
            exe_wen_q   <= id_wb_wen;
            exe_load_q  <= id_is_load;
            exe_store_q <= id_is_store;
            exe_regw_q  <= id_regw_addr;
            exe_rt_q    <= id_addr_rt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || mem_rst) begin
            mem_alu_q   <= '0;
            mem_sdata_q <= '0;
            mem_valid_q <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_load_q  <= 1'b0;
            mem_store_q <= 1'b0;
            mem_regw_q  <= '0;
            mem_rt_q    <= '0;
        end else if (mem_en) begin
            mem_alu_q   <= exe_alu_out;
            mem_sdata_q <= exe_opb_q;
            mem_valid_q <= exe_valid_q;
            mem_wen_q   <= exe_wen_q;
            mem_load_q  <= exe_load_q;
            mem_store_q <= exe_store_q;
            mem_regw_q  <= exe_regw_q;
            mem_rt_q    <= exe_rt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || wb_rst) begin
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_wen_q   <= 1'b0;
            wb_regw_q  <= '0;
        end else if (wb_en) begin
            wb_data_q  <= wb_data_d;
            wb_valid_q <= mem_valid_q;
            wb_wen_q   <= mem_wen_q;
            wb_regw_q  <= mem_regw_q;
        end
    end

    assign exe_opa       = exe_opa_q;
    assign exe_opb       = exe_opb_q;
    assign exe_valid     = exe_valid_q;
    assign regw_addr_exe = exe_regw_q;
    assign wb_wen_exe    = exe_wen_q;
    assign is_load_exe   = exe_load_q;
    assign is_store_exe  = exe_store_q;

    assign mem_valid     = mem_valid_q;
    assign regw_addr_mem = mem_regw_q;
    assign wb_wen_mem    = mem_wen_q;
    assign is_load_mem   = mem_load_q;
    assign is_store_mem  = mem_store_q;
    assign addr_rt_mem   = mem_rt_q;
    assign mem_addr      = mem_alu_q;
    assign mem_wdata     = fwd_mem ? wb_data_q : mem_sdata_q;

    assign wb_valid      = wb_valid_q;
    assign regw_addr_wb  = wb_regw_q;
    assign wb_wen_wb     = wb_wen_q;
    assign wb_data       = wb_data_q;

endmodule

// File: doc/pipe_fwd_datapath.md
Name: pipe_fwd_datapath

Overview:
- Datapath counterpart to the pipeline controller.
- Holds the ID/EXE, EXE/MEM and MEM/WB pipeline registers. It loads, holds or flushes them under the controller's per-stage en/rst signals.
- Applies the controller's forwarding selects (fwd_a, fwd_b, fwd_mem) to the operands.
- Returns the per-stage hazard feedback tags (write address, write enable, load/store flags) that the controller uses for stall and forwarding decisions.

Parameters:
- DATA_W, 32, datapath word width.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  main clock.
- rst_n  in  1  asynchronous active-low reset.
- exe_en, exe_rst, mem_en, mem_rst, wb_en, wb_rst  in  1 each  stage enable and synchronous flush, from the controller.
- fwd_a, fwd_b  in  2 each  operand A/B source: 0 regfile, 1 EXE ALU result, 2 MEM ALU result, 3 MEM load data.
- fwd_mem  in  1  store data source: 1 = WB write data.
- id_rs_data, id_rt_data  in  DATA_W each  register-file read data in ID.
- id_regw_addr  in  REG_AW  resolved destination register of the ID instruction.
- id_addr_rt  in  REG_AW  rt field of the ID instruction.
- id_wb_wen, id_is_load, id_is_store  in  1 each  decoded ID tags.
- exe_alu_out  in  DATA_W  combinational ALU result of the EXE instruction.
- mem_rdata  in  DATA_W  combinational data-memory read data in MEM.
- exe_opa, exe_opb  out  DATA_W each  registered, forwarded operands for EXE.
- exe_valid, mem_valid, wb_valid  out  1 each  stage holds a real instruction.
- regw_addr_exe, wb_wen_exe, is_load_exe, is_store_exe  out  feedback tags from EXE.
- regw_addr_mem, wb_wen_mem, is_load_mem, is_store_mem, addr_rt_mem  out  feedback tags from MEM.
- mem_addr  out  DATA_W  registered EXE ALU result, used as the MEM address.
- mem_wdata  out  DATA_W  store data to data memory.
- regw_addr_wb, wb_wen_wb  out  feedback tags and register-file write port.
- wb_data  out  DATA_W  register-file write data.

Behaviour:
- Async reset (rst_n = 0): every stage register is cleared to a bubble.
  - All valid, wen, is_load and is_store flags = 0.
  - All addresses = 0; all data = 0.
  - Therefore every output resets to 0.
- Per-stage update on rising clk, in priority order:
  1. stage_rst = 1 → load a bubble. Flush wins over en.
  2. else stage_en = 1 → load from the previous stage.
  3. else hold.
- ID→EXE operand muxes (combinational, in ID); the result is registered into exe_opa/exe_opb.
  - Select 0 → id_rs_data / id_rt_data.
  - Select 1 → exe_alu_out.
  - Select 2 → the EXE/MEM ALU-result register.
  - Select 3 → mem_rdata.
  - The same encoding applies independently to A and B.
- The EXE register also captures the ID tags plus store data = forwarded B operand, giving valid = 1. A flush gives valid = 0.
- EXE→MEM captures exe_alu_out, the store data, the EXE tags and addr_rt.
- MEM→WB captures wb_data = is_load_mem ? mem_rdata : MEM ALU result, plus regw_addr and wen.
- mem_wdata is combinational: fwd_mem ? wb_data : MEM store-data register.
- Feedback tags are driven directly from the stage registers. A bubble always presents wen = 0, is_load = 0, is_store = 0, which guarantees the controller never forwards from or stalls on a bubble.
- Load-use stall: the controller asserts exe_rst = 1 with exe_en = 1. EXE becomes a bubble while MEM and WB advance. The ID inputs are held by the controller, and the ID operands are re-selected on the next cycle.
- Latency: ID to register write is 3 clock edges; there is no internal back-pressure.
- Writes to register 0: this block passes them through unchanged. The register file ignores them, and the controller never forwards address 0.
- Simultaneous flush of all stages: all three registers become bubbles on the same edge.
- rst_n deasserting mid-clock: it takes effect asynchronously; the next rising edge proceeds normally.

Test Plan:
- Forward from EXE, ADD then dependent ADD: EXE holds exe_alu_out = 0x0000_0007, fwd_a = 1, id_rs_data = 0x5 → exe_opa = 0x7 after the edge.
- Load-use stall: is_load_exe = 1, exe_rst = 1 for one cycle → exe_valid = 0 and wb_wen_exe = 0. Next cycle fwd_b = 3 with mem_rdata = 0xDEAD_BEEF → exe_opb = 0xDEADBEEF.
- Store forwarding from WB: the WB instruction writes r8 = 0x1234; a store with rt = 8 is in MEM with store data 0x0; fwd_mem = 1 → mem_wdata = 0x1234. With fwd_mem = 0 → mem_wdata = 0x0.
- Hold and flush priority:
  - mem_en = 0 for 2 cycles → all MEM outputs are unchanged.
  - mem_rst = 1 with mem_en = 1 → mem_valid = 0, wb_wen_mem = 0.
- Load write-back: a load in MEM with mem_rdata = 0xCAFE_0001 advances → wb_data = 0xCAFE0001, wb_wen_wb = 1, and regw_addr_wb equals the ID-supplied rt.
- Async reset mid-pipeline: pull rst_n low between clock edges with all stages valid → every output is 0 immediately, without waiting for clk.
